// File: rtl/tpu_pkg.sv
// Shared types and field constants for the tiny-TPU program sequencer.
package tpu_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int IMM_W  = 13;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        OP_NOP         = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUT  = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_HALT        = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        LOAD_W,
        LOAD_I,
        COMP,
        DONE
    } state_t;

endpackage

// File: rtl/tpu_instr_decode.sv
// Pure combinational split of a 16-bit instruction into opcode, immediate and count.
module tpu_instr_decode
    import tpu_pkg::*;
(
    input  logic [15:0]      instr,
    output opcode_t          opcode,
    output logic [IMM_W-1:0] imm,
    output logic [CNT_W-1:0] count,
    output logic             is_illegal
);

    logic [2:0] opc;

    assign opc        = instr[OPC_HI:OPC_LO];
    assign is_illegal = (opc == 3'b101) || (opc == 3'b110);
    // Undefined encodings are mapped to NOP so the enum never holds a stray value.
    assign opcode     = is_illegal ? OP_NOP : opcode_t'(opc);
    assign imm        = instr[IMM_W-1:0];
    assign count      = instr[CNT_W-1:0];

endmodule

// File: rtl/tpu_sequencer.sv
// Fetch/decode FSM that sequences unified-buffer loads and array compute for the tiny TPU.
// Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle completion pulse.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int ARRAY_N = 2,
    parameter int PC_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [PC_W-1:0]            instr_addr,
    input  logic [15:0]                instr_data,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       load_weight,
    output logic                       load_input,
    output logic [$clog2(ARRAY_N)-1:0] row_idx,
    output logic                       compute_en,
    output logic                       busy,
    output logic                       done,
    output logic                       illegal,
    output state_t                     dbg_state
);

    localparam int ROW_W = $clog2(ARRAY_N);

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [ROW_W-1:0]  row, row_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              illegal_nx;
    logic              is_load_nx;

    opcode_t           opcode;
    logic [IMM_W-1:0]  imm;
    logic [CNT_W-1:0]  count;
    logic              is_illegal;

    tpu_instr_decode u_decode (
        .instr      (instr_data),
        .opcode     (opcode),
        .imm        (imm),
        .count      (count),
        .is_illegal (is_illegal)
    );

    assign instr_addr = pc;
    assign dbg_state  = state;

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        base_nx    = base;
        row_nx     = row;
        cnt_nx     = cnt;
        illegal_nx = illegal;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = FETCH;
                    pc_nx      = '0;
                    illegal_nx = 1'b0;
                end
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                pc_nx  = pc + PC_W'(1);
                row_nx = '0;
                case (opcode)
                    OP_LOAD_ADDR: begin
                        base_nx  = ADDR_W'(imm);
                        state_nx = FETCH;
                    end
                    OP_LOAD_WEIGHT: state_nx = LOAD_W;
                    OP_LOAD_INPUT:  state_nx = LOAD_I;
                    OP_COMPUTE: begin
                        if (count != '0) begin
                            state_nx = COMP;
                            cnt_nx   = count - CNT_W'(1);
                        end else begin
                            state_nx = FETCH;
                        end
                    end
                    OP_HALT: state_nx = DONE;
                    default: state_nx = FETCH;
                endcase
                if (is_illegal) begin
                    state_nx   = DONE;
                    illegal_nx = 1'b1;
                end
            end
            LOAD_W, LOAD_I: begin
                if (row == ROW_W'(ARRAY_N - 1)) begin
                    state_nx = FETCH;
                    base_nx  = base + ADDR_W'(ARRAY_N);
                end else begin
                    row_nx = row + ROW_W'(1);
                end
            end
            COMP: begin
                // cnt holds the beats remaining after the current one.
                if (cnt == '0) state_nx = FETCH;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign is_load_nx = (state_nx == LOAD_W) || (state_nx == LOAD_I);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            base        <= '0;
            row         <= '0;
            cnt         <= '0;
            illegal     <= 1'b0;
            load_weight <= 1'b0;
            load_input  <= 1'b0;
            compute_en  <= 1'b0;
            mem_addr    <= '0;
            row_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            base        <= base_nx;
            row         <= row_nx;
            cnt         <= cnt_nx;
            illegal     <= illegal_nx;
            load_weight <= (state_nx == LOAD_W);
            load_input  <= (state_nx == LOAD_I);
            compute_en  <= (state_nx == COMP);
            mem_addr    <= is_load_nx ? (base + ADDR_W'(row_nx)) : '0;
            row_idx     <= is_load_nx ? row_nx : '0;
            busy        <= (state_nx == FETCH) || (state_nx == DECODE) || (state_nx == LOAD_W) ||
                           (state_nx == LOAD_I) || (state_nx == COMP);
            done        <= (state_nx == DONE);
        end
    end

endmodule
